// File: rtl/simd_pkg.sv
// simd_pkg: shared opcodes, FSM states, instruction field layout and word builder.
package simd_pkg;

    localparam int N_DEFAULT = 16;
    localparam int INSTR_W   = 32;
    localparam int OPC_LSB   = 0;
    localparam int OPC_W     = 3;
    localparam int IDX_LSB   = 3;
    localparam int IDX_W     = 4;
    localparam int OFF_BIT   = 7;

    typedef enum logic [OPC_W-1:0] {
        OP_IDLE   = 3'd0,
        OP_FETCHB = 3'd1,
        OP_FETCHA = 3'd2,
        OP_MATMUL = 3'd3,
        OP_STORE  = 3'd4
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_HALT,
        S_ERR
    } state_e;

    function automatic logic [INSTR_W-1:0] make_instr(
        input opcode_e          op,
        input logic [IDX_W-1:0] idx,
        input logic             off
    );
        logic [INSTR_W-1:0] w;
        w                      = '0;
        w[OPC_LSB +: OPC_W]    = op;
        w[IDX_LSB +: IDX_W]    = idx;
        w[OFF_BIT]             = off;
        return w;
    endfunction

endpackage

// File: rtl/issue_watchdog.sv
// issue_watchdog: cycle counter that flags a stalled handshake phase.
//   CLK, RSTN : clock, asynchronous active-low reset
//   clear     : restart count from zero (takes priority)
//   enable    : count this cycle
//   expired   : enable is high and this is the TIMEOUT_CYC-th counted cycle
module issue_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expiry is flagged during the last allowed cycle so the owner leaves
    // the phase exactly TIMEOUT_CYC cycles after entering it.
    assign expired = enable && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = clear ? '0 : (enable && !expired) ? cnt_q + CW'(1) : cnt_q;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/instr_issuer.sv
// instr_issuer: issues the matrix-multiply instruction program over a hold/done handshake.
//   CLK, RSTN : clock, asynchronous active-low reset
//   START     : one-cycle program start request (ignored while busy)
//   DONE      : consumer finished the held instruction
//   OFFSWT    : consumer acknowledged the halt word
//   INSTR     : instruction word {off, index, opcode}, registered
//   ONSWT     : instruction valid/hold, registered
//   BUSY      : program in progress
//   FINISH    : one-cycle completion pulse
//   ERR       : sticky handshake timeout
module instr_issuer
    import simd_pkg::*;
#(
    parameter int N           = N_DEFAULT,
    parameter int LOGN        = $clog2(N),
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               START,
    input  logic               DONE,
    input  logic               OFFSWT,
    output logic [INSTR_W-1:0] INSTR,
    output logic               ONSWT,
    output logic               BUSY,
    output logic               FINISH,
    output logic               ERR
);

    localparam logic [LOGN-1:0]    LAST_IDX  = LOGN'(N - 1);
    localparam logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(1) << OFF_BIT;

    state_e             state_q, state_d;
    logic [LOGN-1:0]    b_q, b_d;
    logic [LOGN-1:0]    row_q, row_d;
    logic [1:0]         sub_q, sub_d;
    logic               rows_q, rows_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               onswt_q, onswt_d;
    logic               busy_q, busy_d;
    logic               finish_q, finish_d;
    logic               err_q, err_d;
    logic               expired;
    logic               last;
    logic               advance;
    logic               start_acc;
    opcode_e            sub_op;
    logic [INSTR_W-1:0] word;

    // rows_q=0 is the FETCHB phase, so the all-zero reset pointer is instruction 0.
    assign sub_op    = (sub_q == 2'd0) ? OP_FETCHA : (sub_q == 2'd1) ? OP_MATMUL : OP_STORE;
    assign word      = rows_q ? make_instr(sub_op, IDX_W'(row_q), 1'b0)
                              : make_instr(OP_FETCHB, IDX_W'(b_q), 1'b0);
    assign last      = rows_q && (row_q == LAST_IDX) && (sub_q == 2'd2);
    assign advance   = (state_q == S_GAP) && !DONE;
    assign start_acc = ((state_q == S_IDLE) || (state_q == S_ERR)) && START;

    issue_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wd (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .clear   (state_d != state_q),
        .enable  ((state_q == S_WAIT) || (state_q == S_GAP) || (state_q == S_HALT)),
        .expired (expired)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= S_IDLE;
            b_q      <= '0;
            row_q    <= '0;
            sub_q    <= '0;
            rows_q   <= 1'b0;
            instr_q  <= '0;
            onswt_q  <= 1'b0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            row_q    <= row_d;
            sub_q    <= sub_d;
            rows_q   <= rows_d;
            instr_q  <= instr_d;
            onswt_q  <= onswt_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
            err_q    <= err_d;
        end
    end

    // Next state and program pointer. Handshake progress is tested before
    // the watchdog so a progress event in the expiry cycle wins.
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        row_d   = row_q;
        sub_d   = sub_q;
        rows_d  = rows_q;
        case (state_q)
            S_IDLE, S_ERR: state_d = START ? S_ISSUE : state_q;
            S_ISSUE:       state_d = S_WAIT;
            S_WAIT:        state_d = DONE ? S_GAP : expired ? S_ERR : S_WAIT;
            S_GAP:         state_d = !DONE ? (last ? S_HALT : S_ISSUE) : expired ? S_ERR : S_GAP;
            S_HALT:        state_d = OFFSWT ? S_IDLE : expired ? S_ERR : S_HALT;
            default:       state_d = S_IDLE;
        endcase
        if (start_acc) begin
            b_d    = '0;
            row_d  = '0;
            sub_d  = '0;
            rows_d = 1'b0;
        end else if (advance && !rows_q) begin
            b_d    = (b_q == LAST_IDX) ? '0 : b_q + LOGN'(1);
            rows_d = (b_q == LAST_IDX);
        end else if (advance) begin
            sub_d  = (sub_q == 2'd2) ? 2'd0 : sub_q + 2'd1;
            row_d  = (sub_q != 2'd2) ? row_q : (row_q == LAST_IDX) ? '0 : row_q + LOGN'(1);
            rows_d = !last;
        end
    end

    // Outputs are registered from the next state so every port comes straight off a flop.
    always_comb begin
        instr_d  = (state_q == S_ISSUE) ? word :
                   (state_d == S_WAIT)  ? instr_q :
                   (state_d == S_HALT)  ? HALT_WORD : '0;
        onswt_d  = (state_d == S_WAIT);
        busy_d   = (state_d == S_ISSUE) || (state_d == S_WAIT) ||
                   (state_d == S_GAP)   || (state_d == S_HALT);
        finish_d = (state_q == S_HALT) && OFFSWT;
        err_d    = (state_d == S_ERR);
    end

    assign INSTR  = instr_q;
    assign ONSWT  = onswt_q;
    assign BUSY   = busy_q;
    assign FINISH = finish_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_instr_issuer.sv
// tb_instr_issuer: directed self-checking bench for instr_issuer.
module tb_instr_issuer;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        START = 1'b0;
    logic        DONE = 1'b0;
    logic        OFFSWT = 1'b0;
    logic [31:0] INSTR;
    logic        ONSWT, BUSY, FINISH, ERR;

    int n_tests = 0;
    int n_fail  = 0;
    int fin_cnt = 0;

    instr_issuer dut (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .START  (START),
        .DONE   (DONE),
        .OFFSWT (OFFSWT),
        .INSTR  (INSTR),
        .ONSWT  (ONSWT),
        .BUSY   (BUSY),
        .FINISH (FINISH),
        .ERR    (ERR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (FINISH === 1'b1) fin_cnt++;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int k);
        int op, idx;
        if (k < 16) begin
            op  = 1;
            idx = k;
        end else begin
            op  = 2 + (k - 16) % 3;
            idx = (k - 16) / 3;
        end
        return 32'(idx * 8 + op);
    endfunction

    task automatic wait_onswt(input logic val, input string tag);
        int i;
        for (i = 0; i < 20 && ONSWT !== val; i++) tick();
        if (ONSWT !== val) check(tag, {31'd0, ONSWT}, {31'd0, val});
    endtask

    // One instruction with the consumer raising DONE two cycles after ONSWT rises.
    task automatic do_instr(input int k, input logic poke);
        wait_onswt(1'b1, $sformatf("rise%0d", k));
        check($sformatf("instr%0d", k), INSTR, exp_word(k));
        START = poke;
        tick();
        START = 1'b0;
        tick();
        DONE = 1'b1;
        wait_onswt(1'b0, $sformatf("fall%0d", k));
        DONE = 1'b0;
        check($sformatf("gap%0d", k), INSTR, 32'h0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_instr", INSTR, 32'h0);
        check("rst_onswt", {31'd0, ONSWT}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_finish", {31'd0, FINISH}, 32'd0);
        check("rst_err", {31'd0, ERR}, 32'd0);
        RSTN = 1'b1;
        repeat (3) tick();
        check("idle_onswt", {31'd0, ONSWT}, 32'd0);
        check("idle_busy", {31'd0, BUSY}, 32'd0);

        // Full program, with a stray START while busy
        START = 1'b1;
        tick();
        START = 1'b0;
        check("issue_busy", {31'd0, BUSY}, 32'd1);
        check("issue_onswt", {31'd0, ONSWT}, 32'd0);
        for (int k = 0; k < 64; k++) begin
            do_instr(k, k == 10);
            if (k == 10) check("busy_mid", {31'd0, BUSY}, 32'd1);
        end
        for (int i = 0; i < 5 && INSTR !== 32'h80; i++) tick();
        check("halt_word", INSTR, 32'h80);
        check("halt_onswt", {31'd0, ONSWT}, 32'd0);
        check("halt_busy", {31'd0, BUSY}, 32'd1);
        repeat (3) tick();
        check("halt_hold", INSTR, 32'h80);
        check("halt_nofin", {31'd0, FINISH}, 32'd0);
        OFFSWT = 1'b1;
        tick();
        OFFSWT = 1'b0;
        check("finish_pulse", {31'd0, FINISH}, 32'd1);
        check("finish_busy", {31'd0, BUSY}, 32'd0);
        check("finish_instr", INSTR, 32'h0);
        tick();
        check("finish_drop", {31'd0, FINISH}, 32'd0);
        repeat (3) tick();
        check("finish_count", 32'(fin_cnt), 32'd1);
        check("run_err", {31'd0, ERR}, 32'd0);

        // DONE already high when ONSWT rises: exactly one WAIT cycle
        DONE = 1'b1;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("pre_issue_onswt", {31'd0, ONSWT}, 32'd0);
        tick();
        check("pre_wait_onswt", {31'd0, ONSWT}, 32'd1);
        check("pre_wait_instr", INSTR, 32'h01);
        tick();
        check("pre_gap_onswt", {31'd0, ONSWT}, 32'd0);
        repeat (3) tick();
        check("pre_gap_hold", {31'd0, ONSWT}, 32'd0);
        DONE = 1'b0;
        for (int k = 1; k < 4; k++) do_instr(k, 1'b0);

        // Timeout on the 5th instruction
        wait_onswt(1'b1, "rise_to");
        check("to_instr", INSTR, 32'h21);
        repeat (63) tick();
        check("to_err_before", {31'd0, ERR}, 32'd0);
        tick();
        check("to_err", {31'd0, ERR}, 32'd1);
        check("to_onswt", {31'd0, ONSWT}, 32'd0);
        check("to_busy", {31'd0, BUSY}, 32'd0);
        check("to_instr0", INSTR, 32'h0);
        repeat (3) tick();
        check("to_sticky", {31'd0, ERR}, 32'd1);
        START = 1'b1;
        tick();
        START = 1'b0;
        check("to_err_clear", {31'd0, ERR}, 32'd0);
        do_instr(0, 1'b0);

        // DONE in the expiry cycle wins
        wait_onswt(1'b1, "rise_race");
        check("race_instr", INSTR, 32'h09);
        repeat (63) tick();
        check("race_err_before", {31'd0, ERR}, 32'd0);
        DONE = 1'b1;
        tick();
        check("race_err", {31'd0, ERR}, 32'd0);
        check("race_gap", {31'd0, ONSWT}, 32'd0);
        check("race_busy", {31'd0, BUSY}, 32'd1);
        DONE = 1'b0;
        for (int k = 2; k < 38; k++) do_instr(k, 1'b0);

        // Reset during MATMUL row 7
        wait_onswt(1'b1, "rise_mm7");
        check("mm7_instr", INSTR, 32'h3B);
        #2;
        RSTN = 1'b0;
        #1;
        check("arst_instr", INSTR, 32'h0);
        check("arst_onswt", {31'd0, ONSWT}, 32'd0);
        check("arst_busy", {31'd0, BUSY}, 32'd0);
        repeat (2) tick();
        RSTN = 1'b1;
        repeat (5) tick();
        check("post_rst_onswt", {31'd0, ONSWT}, 32'd0);
        check("post_rst_busy", {31'd0, BUSY}, 32'd0);
        check("post_rst_instr", INSTR, 32'h0);
        START = 1'b1;
        tick();
        START = 1'b0;
        do_instr(0, 1'b0);
        do_instr(1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
